fdivsqrtexp: RTL and testbench

FDIVSQRTEXP -- requirements
Module: fdivsqrtexp

---
 rtl/fdivsqrtexp.sv | 102 ++++++++++
 tb/tb_fdivsqrtexp.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fdivsqrtexp.sv
// fdivsqrtexp: exponent/control path of an iterative divide/sqrt unit.
// Square root is enabled by defining FDIVSQRTEXP_SQRT_EN; otherwise every operation is a division.
module fdivsqrtexp #(
    parameter int NE   = 11,
    parameter int BIAS = 1023,
    parameter int LZW  = 6,
    parameter int ITER = 28
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Start,
    input  logic          SqrtE,
    input  logic [NE-1:0] Xe,
    input  logic [NE-1:0] Ye,
    input  logic [LZW-1:0] Xlz,
    input  logic [LZW-1:0] Ylz,
    input  logic          XZero,
    input  logic          YZero,
    input  logic          Flush,
    input  logic          ResultAck,
    output logic          Ready,
    output logic          Busy,
    output logic          Valid,
    output logic [NE+1:0] Qe,
    output logic          OddExp,
    output logic          DivZero
);
    localparam int W  = NE + 2;
    localparam int CW = $clog2(ITER + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [NE-1:0] xe_r, ye_r;
    logic [LZW-1:0] xlz_r, ylz_r;
    logic xz_r, yz_r, sq_r, sq, accept, first;
    logic [W-1:0] xeff, yeff, u, qe_n;
`ifdef FDIVSQRTEXP_SQRT_EN
    assign sq = sq_r;
`else
    logic unused_sq;
    assign unused_sq = sq_r;
    assign sq = 1'b0;
`endif
    assign xeff = {2'b00, xe_r} - {{(W-LZW){1'b0}}, xlz_r};
    assign yeff = {2'b00, ye_r} - {{(W-LZW){1'b0}}, ylz_r};
    assign u = xeff - W'(BIAS);
    assign qe_n = (xz_r || (!sq && yz_r)) ? '0 :
                  sq ? {u[W-1], u[W-1:1]} + W'(BIAS) : xeff - yeff + W'(BIAS);
    // the counter still holds its load value only in the first BUSY cycle
    assign first = state == BUSY && cnt == CW'(ITER - 1);
    assign Ready = state == IDLE;
    assign Busy  = state == BUSY;
    assign Valid = state == DONE;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        accept = 1'b0;
        unique case (state)
            IDLE: if (Start) begin
                state_n = BUSY;
                cnt_n = CW'(ITER - 1);
                accept = 1'b1;
            end
            BUSY: if (xz_r || yz_r || cnt == '0) state_n = DONE;
                  else cnt_n = cnt - CW'(1);
            DONE: if (ResultAck) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (Flush) begin
            state_n = IDLE;
            cnt_n = cnt;
            accept = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            Qe <= '0;
            OddExp <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (first) begin
                Qe <= qe_n;
                OddExp <= sq & u[0];
                DivZero <= !sq && yz_r && !xz_r;
            end
        end
    end
    always_ff @(posedge clk)
        if (accept) begin
            xe_r <= Xe;
            ye_r <= Ye;
            xlz_r <= Xlz;
            ylz_r <= Ylz;
            xz_r <= XZero;
            yz_r <= YZero;
            sq_r <= SqrtE;
        end
endmodule

// File: tb/tb_fdivsqrtexp.sv
// tb_fdivsqrtexp: randomized and directed checks of fdivsqrtexp against an integer reference model.
module tb_fdivsqrtexp;
    localparam int NE = 11, BIAS = 1023, LZW = 6, ITER = 28, W = NE + 2;
`ifdef FDIVSQRTEXP_SQRT_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, Start = 1'b0, SqrtE = 1'b0, XZero = 1'b0, YZero = 1'b0;
    logic Flush = 1'b0, ResultAck = 1'b0;
    logic [NE-1:0] Xe = '0, Ye = '0;
    logic [LZW-1:0] Xlz = '0, Ylz = '0;
    logic Ready, Busy, Valid, OddExp, DivZero;
    logic [W-1:0] Qe;
    int vectors = 0, errors = 0;

    fdivsqrtexp #(.NE(NE), .BIAS(BIAS), .LZW(LZW), .ITER(ITER)) dut (
        .clk(clk), .reset(reset), .Start(Start), .SqrtE(SqrtE), .Xe(Xe), .Ye(Ye),
        .Xlz(Xlz), .Ylz(Ylz), .XZero(XZero), .YZero(YZero), .Flush(Flush),
        .ResultAck(ResultAck), .Ready(Ready), .Busy(Busy), .Valid(Valid),
        .Qe(Qe), .OddExp(OddExp), .DivZero(DivZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // returns {DivZero, OddExp, Qe}
    function automatic logic [W+1:0] model(bit sq, int xe, int ye, int xlz, int ylz, bit xz, bit yz);
        int xeff = xe - xlz, yeff = ye - ylz, u, q;
        bit odd = 1'b0, dz = 1'b0;
        if (sq && SQ_EN) begin
            u = xeff - BIAS;
            q = (u >>> 1) + BIAS;
            odd = u[0];
        end else begin
            q = yz ? 0 : xeff - yeff + BIAS;
            dz = yz && !xz;
        end
        if (xz) q = 0;
        return {dz, odd, q[W-1:0]};
    endfunction

    task automatic op(input bit sq, input int xe, input int ye, input int xlz, input int ylz,
                      input bit xz, input bit yz, input int hold);
        logic [W+1:0] exp = model(sq, xe, ye, xlz, ylz, xz, yz);
        int k = 0;
        bit ok = 1'b1;
        logic [W-1:0] q0;
        check("ready_before", Ready, 1'b1);
        Start = 1'b1; SqrtE = sq; Xe = NE'(xe); Ye = NE'(ye); Xlz = LZW'(xlz); Ylz = LZW'(ylz);
        XZero = xz; YZero = yz;
        tick();
        Start = 1'b0;
        Xe = NE'($urandom); Ye = NE'($urandom); Xlz = LZW'($urandom); Ylz = LZW'($urandom);
        XZero = 1'(~xz); YZero = 1'(~yz); SqrtE = ~sq;
        while (!Valid && k < 100) begin
            if (!Busy || Ready) ok = 1'b0;
            tick();
            k++;
        end
        check("busy_phase", ok, 1'b1);
        check("latency", k + 1, (xz || yz) ? 2 : ITER + 1);
        check("qe", Qe, exp[W-1:0]);
        check("oddexp", OddExp, exp[W]);
        check("divzero", DivZero, exp[W+1]);
        check("onehot", {Ready, Busy, Valid}, 3'b001);
        q0 = Qe;
        Start = 1'b1;
        repeat (hold) tick();
        Start = 1'b0;
        if (hold > 0) check("hold", {Valid, Qe, OddExp, DivZero}, {1'b1, q0, exp[W], exp[W+1]});
        ResultAck = 1'b1;
        tick();
        ResultAck = 1'b0;
        check("ack_ready", {Ready, Busy, Valid}, 3'b100);
    endtask

    initial begin
        bit seen;
        #1;
        repeat (3) tick();
        check("rst_state", {Ready, Busy, Valid}, 3'b100);
        check("rst_outs", {Qe, OddExp, DivZero}, '0);
        reset = 1'b0;
        op(0, 1024, 1023, 0, 0, 0, 0, 0);
        op(1, 1025, 7, 0, 0, 0, 0, 0);
        op(1, 1024, 7, 0, 0, 0, 0, 0);
        op(1, 1022, 7, 0, 0, 0, 0, 0);
        op(0, 1, 1023, 3, 0, 0, 0, 0);
        op(0, 1000, 5, 0, 0, 0, 1, 0);
        op(0, 1000, 5, 0, 0, 1, 0, 0);
        op(0, 2046, 1, 0, 63, 0, 0, 5);
        // flush in the 10th BUSY cycle together with a Start
        Start = 1'b1; SqrtE = 1'b0; Xe = 11'd1500; Ye = 11'd900; XZero = 1'b0; YZero = 1'b0;
        tick();
        Start = 1'b0;
        repeat (9) tick();
        Flush = 1'b1; Start = 1'b1;
        tick();
        Flush = 1'b0; Start = 1'b0;
        check("flush_ready", {Ready, Busy, Valid}, 3'b100);
        seen = 1'b0;
        repeat (40) begin
            if (!Ready || Valid) seen = 1'b1;
            tick();
        end
        check("flush_quiet", seen, 1'b0);
        // reset mid-operation
        Start = 1'b1; Xe = 11'd1200;
        tick();
        Start = 1'b0;
        repeat (5) tick();
        reset = 1'b1; Flush = 1'b1;
        tick();
        reset = 1'b0; Flush = 1'b0;
        check("midrst", {Ready, Busy, Valid, Qe, OddExp, DivZero}, {3'b100, {(W+2){1'b0}}});
        seen = 1'b0;
        repeat (35) begin
            if (!Ready || Valid) seen = 1'b1;
            tick();
        end
        check("midrst_quiet", seen, 1'b0);
        for (int i = 0; i < 40; i++)
            op(1'($urandom), int'($urandom_range(1, 2046)), int'($urandom_range(1, 2046)),
               int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
